// File: rtl/hamming_sec_ded_dec16_pkg.sv
// hamming16_pkg: code layout, parity helper and error classes for the 16-bit SEC-DED code
package hamming16_pkg;
  localparam int DATA_W = 16;
  localparam int HCHK_W = 5;
  localparam int CW_LAST = 21;
  localparam logic [4:0] DATA_POS [DATA_W] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12,
                                               5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};
  // bit j of CHK_MASK[i] is set when DATA_POS[j] has bit i set
  localparam logic [DATA_W-1:0] CHK_MASK [HCHK_W] = '{16'hAD5B, 16'h366D, 16'hC78E, 16'h07F0, 16'hF800};
  typedef enum logic [1:0] {CLEAN, SEC, DED} err_class_t;
  function automatic logic [HCHK_W-1:0] hamming_parity(input logic [DATA_W-1:0] d);
    logic [HCHK_W-1:0] p;
    for (int i = 0; i < HCHK_W; i++) p[i] = ^(d & CHK_MASK[i]);
    return p;
  endfunction
endpackage

// File: rtl/hamming_sec_ded_dec16_if.sv
// hamming_sec_ded_dec16_if: word-in / word-out valid-ready bundle of the SEC-DED decoder
interface hamming_sec_ded_dec16_if;
  import hamming16_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] data_in;
  logic [HCHK_W:0] chk_in;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] data_out;
  logic [HCHK_W-1:0] syndrome;
  logic sec_err;
  logic ded_err;
  modport master (output in_valid, data_in, chk_in, out_ready,
                  input in_ready, out_valid, data_out, syndrome, sec_err, ded_err);
  modport slave (input in_valid, data_in, chk_in, out_ready,
                 output in_ready, out_valid, data_out, syndrome, sec_err, ded_err);
endinterface

// File: rtl/hamming_sec_ded_dec16_syndrome.sv
// hamming_syndrome16: syndrome and overall mismatch of a received word; HAMMING_DED_EN enables the overall parity check
module hamming_syndrome16
  import hamming16_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [HCHK_W:0]   chk_i,
  output logic [HCHK_W-1:0] syn_o,
  output logic              pm_o
);
  assign syn_o = chk_i[HCHK_W-1:0] ^ hamming_parity(data_i);
`ifdef HAMMING_DED_EN
  assign pm_o = ^{chk_i, data_i};
`else
  // without the overall bit every nonzero syndrome is taken as a single error
  logic unused_par;
  assign unused_par = chk_i[HCHK_W];
  assign pm_o = |syn_o;
`endif
endmodule

// File: rtl/hamming_sec_ded_dec16.sv
// hamming_sec_ded_dec16: 2-stage SEC-DED decoder with saturating stats; HAMMING_DED_EN selects full DED vs SEC-only
module hamming_sec_ded_dec16
  import hamming16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  hamming_sec_ded_dec16_if.slave bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      sec_cnt,
  output logic [CNT_W-1:0]      ded_cnt
);
  logic s1_valid_q, s1_valid_d, s1_pm_q, s1_pm_d, pm;
  logic [DATA_W-1:0] s1_data_q, s1_data_d, fix, data_out_q, data_out_d;
  logic [HCHK_W-1:0] s1_syn_q, s1_syn_d, syn, syn_q, syn_d;
  logic out_valid_q, out_valid_d, sec_q, sec_d, ded_q, ded_d;
  logic s1_adv, in_fire, out_fire, ld2;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
  err_class_t cls;

  hamming_syndrome16 u_syn (.data_i(bus.data_in), .chk_i(bus.chk_in), .syn_o(syn), .pm_o(pm));

  assign s1_adv = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign ld2 = s1_adv && s1_valid_q;
  assign cls = (s1_syn_q == '0 && !s1_pm_q) ? CLEAN :
               (s1_pm_q && s1_syn_q <= HCHK_W'(CW_LAST)) ? SEC : DED;

  // syndromes naming a check-bit position match no data bit and leave data alone
  for (genvar j = 0; j < DATA_W; j++) begin : g_fix
    assign fix[j] = (cls == SEC) && (s1_syn_q == DATA_POS[j]);
  end

  always_comb begin
    s1_valid_d = bus.in_ready ? bus.in_valid : s1_valid_q;
    s1_data_d = in_fire ? bus.data_in : s1_data_q;
    s1_syn_d = in_fire ? syn : s1_syn_q;
    s1_pm_d = in_fire ? pm : s1_pm_q;
    out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
    data_out_d = ld2 ? s1_data_q ^ fix : data_out_q;
    syn_d = ld2 ? s1_syn_q : syn_q;
    sec_d = ld2 ? cls == SEC : sec_q;
    ded_d = ld2 ? cls == DED : ded_q;
    sec_cnt_d = cnt_clr ? '0 : (out_fire && sec_q && !(&sec_cnt_q)) ? sec_cnt_q + CNT_W'(1) : sec_cnt_q;
    ded_cnt_d = cnt_clr ? '0 : (out_fire && ded_q && !(&ded_cnt_q)) ? ded_cnt_q + CNT_W'(1) : ded_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q <= '0;
      s1_pm_q <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q <= '0;
      syn_q <= '0;
      sec_q <= 1'b0;
      ded_q <= 1'b0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q <= s1_data_d;
      s1_syn_q <= s1_syn_d;
      s1_pm_q <= s1_pm_d;
      out_valid_q <= out_valid_d;
      data_out_q <= data_out_d;
      syn_q <= syn_d;
      sec_q <= sec_d;
      ded_q <= ded_d;
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out = data_out_q;
  assign bus.syndrome = syn_q;
  assign bus.sec_err = sec_q;
  assign bus.ded_err = ded_q;
  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
endmodule

// File: tb/tb_hamming_sec_ded_dec16.sv
// tb_hamming_sec_ded_dec16: vector table, corner sequences and random scoreboard for the SEC-DED decoder
module tb_hamming_sec_ded_dec16;
  logic clk = 1'b0, rst = 1'b1, cnt_clr = 1'b0;
  logic [7:0] sec_cnt, ded_cnt;
  int checks = 0, failures = 0;

  hamming_sec_ded_dec16_if bus();
  hamming_sec_ded_dec16 #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr),
                                          .sec_cnt(sec_cnt), .ded_cnt(ded_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic [4:0] s; bit sec; bit ded; } res_t;
  typedef struct { logic [15:0] d; logic [5:0] c; logic [15:0] ed; logic [4:0] es; bit esec; bit eded; } vec_t;

  int dpos[16];
  res_t exp_q[$];
  logic [15:0] got_q[$];
  res_t mr;
  int m_sec = 0, m_ded = 0;
  bit hold = 0, in_fire_s = 0;
  logic [23:0] held;
  logic [15:0] wd;
  logic [5:0] wc;
  vec_t tbl[11];
  logic [15:0] sd[4];
  logic [5:0] sc[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: place bits at codeword positions, syndrome = XOR of positions holding a 1
  function automatic res_t ref_dec(input logic [15:0] d, input logic [5:0] c);
    bit cw[32];
    res_t r;
    bit pm;
    int s = 0;
    foreach (cw[p]) cw[p] = 1'b0;
    for (int i = 0; i < 5; i++) cw[1 << i] = c[i];
    for (int j = 0; j < 16; j++) cw[dpos[j]] = d[j];
    for (int p = 1; p <= 21; p++) if (cw[p]) s ^= p;
    pm = c[5];
    for (int p = 1; p <= 21; p++) pm ^= cw[p];
`ifndef HAMMING_DED_EN
    pm = (s != 0);
`endif
    r.s = 5'(s);
    r.sec = (s == 0 && pm) || (s != 0 && pm && s <= 21);
    r.ded = (s != 0 && !pm) || (s > 21);
    if (r.sec && s != 0) cw[s] = !cw[s];
    for (int j = 0; j < 16; j++) r.d[j] = cw[dpos[j]];
    return r;
  endfunction

  function automatic logic [5:0] enc(input logic [15:0] d);
    logic [5:0] c = '0;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 5; i++)
        if (((dpos[j] >> i) & 1) != 0) c[i] ^= d[j];
    c[5] = ^{d, c[4:0]};
    return c;
  endfunction

  // p=0 is the overall parity bit, else a codeword position 1..21
  task automatic flip(inout logic [15:0] d, inout logic [5:0] c, input int p);
    if (p == 0) c[5] = ~c[5];
    for (int i = 0; i < 5; i++) if (p == (1 << i)) c[i] = ~c[i];
    for (int j = 0; j < 16; j++) if (dpos[j] == p) d[j] = ~d[j];
  endtask

  task automatic rand_word(output logic [15:0] d, output logic [5:0] c);
    int k = $urandom_range(0, 3);
    int p = $urandom_range(0, 21);
    int q = (p + $urandom_range(1, 21)) % 22;
    d = 16'($urandom);
    c = enc(d);
    if (k >= 1) flip(d, c, p);
    if (k == 2) flip(d, c, q);
    if (k == 3) c = 6'($urandom);
  endtask

  always @(negedge clk) begin
    chk("sec_cnt", sec_cnt, m_sec);
    chk("ded_cnt", ded_cnt, m_ded);
    in_fire_s = bus.in_valid && bus.in_ready;
    if (rst) begin
      exp_q.delete();
      m_sec = 0;
      m_ded = 0;
      hold = 0;
      in_fire_s = 0;
    end else begin
      if (hold) chk("stall_hold", {bus.out_valid, bus.data_out, bus.syndrome, bus.sec_err, bus.ded_err}, held);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got word %0h with no word pending", bus.data_out);
        end else begin
          mr = exp_q.pop_front();
          chk("sb_data", bus.data_out, mr.d);
          chk("sb_syn", bus.syndrome, mr.s);
          chk("sb_sec", bus.sec_err, mr.sec);
          chk("sb_ded", bus.ded_err, mr.ded);
          got_q.push_back(bus.data_out);
          if (mr.sec && m_sec < 255) m_sec++;
          if (mr.ded && m_ded < 255) m_ded++;
        end
      end
      if (cnt_clr) begin
        m_sec = 0;
        m_ded = 0;
      end
      if (in_fire_s) exp_q.push_back(ref_dec(bus.data_in, bus.chk_in));
      hold = bus.out_valid && !bus.out_ready;
      held = {bus.out_valid, bus.data_out, bus.syndrome, bus.sec_err, bus.ded_err};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int j = 0;
    for (int p = 1; p <= 21; p++) if ((p & (p - 1)) != 0) dpos[j++] = p;
    tbl[0] = '{16'h0000, 6'h00, 16'h0000, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{16'h0001, 6'h00, 16'h0000, 5'd3, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 6'h01, 16'h0000, 5'd1, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 6'h1F, 16'h0000, 5'd31, 1'b0, 1'b1};
    tbl[7] = '{16'hFFFF, 6'h1E, 16'hFFFF, 5'd0, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 6'h00, 16'h0000, 5'd21, 1'b1, 1'b0};
    tbl[9] = '{16'h0000, 6'h10, 16'h0000, 5'd16, 1'b1, 1'b0};
    tbl[10] = '{16'h0000, 6'h16, 16'h0000, 5'd22, 1'b0, 1'b1};
`ifdef HAMMING_DED_EN
    tbl[2] = '{16'h0003, 6'h00, 16'h0003, 5'd6, 1'b0, 1'b1};
    tbl[3] = '{16'h0000, 6'h20, 16'h0000, 5'd0, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 6'h03, 16'h0000, 5'd3, 1'b0, 1'b1};
`else
    tbl[2] = '{16'h0003, 6'h00, 16'h0007, 5'd6, 1'b1, 1'b0};
    tbl[3] = '{16'h0000, 6'h20, 16'h0000, 5'd0, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 6'h03, 16'h0001, 5'd3, 1'b1, 1'b0};
`endif
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.data_in = '0;
    bus.chk_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_syndrome", bus.syndrome, 0);
    chk("rst_flags", {bus.sec_err, bus.ded_err}, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    foreach (tbl[k]) begin
      bus.in_valid = 1;
      bus.data_in = tbl[k].d;
      bus.chk_in = tbl[k].c;
      @(posedge clk); #1 bus.in_valid = 0;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", k), bus.out_valid, 1);
      chk($sformatf("tbl%0d_data", k), bus.data_out, tbl[k].ed);
      chk($sformatf("tbl%0d_syn", k), bus.syndrome, tbl[k].es);
      chk($sformatf("tbl%0d_sec", k), bus.sec_err, tbl[k].esec);
      chk($sformatf("tbl%0d_ded", k), bus.ded_err, tbl[k].eded);
    end
    repeat (3) @(posedge clk);
    #1;

    // backpressure: four clean words against a 3-cycle stall
    for (int i = 0; i < 4; i++) begin
      sd[i] = 16'($urandom);
      sc[i] = enc(sd[i]);
    end
    got_q.delete();
    j = 0;
    bus.out_ready = 0;
    for (int cyc = 0; cyc < 30 && got_q.size() < 4; cyc++) begin
      bus.in_valid = (j < 4);
      if (j < 4) begin
        bus.data_in = sd[j];
        bus.chk_in = sc[j];
      end
      if (cyc == 3) bus.out_ready = 1;
      @(posedge clk); #1;
      if (in_fire_s) j++;
      if (cyc == 1) chk("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 0;
    chk("stall_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk($sformatf("stall_order%0d", i), got_q[i], sd[i]);

    // saturation of the SEC counter
    bus.out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      wd = 16'($urandom);
      wc = enc(wd);
      flip(wd, wc, $urandom_range(1, 21));
      bus.in_valid = 1;
      bus.data_in = wd;
      bus.chk_in = wc;
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    repeat (3) @(posedge clk);
    #1 chk("sec_saturate", sec_cnt, 255);

    // clear wins over a same-cycle flagged handshake
    bus.in_valid = 1;
    bus.data_in = 16'h0001;
    bus.chk_in = 6'h00;
    @(posedge clk); #1 bus.in_valid = 0;
    @(posedge clk); #1;
    chk("clr_word_valid", bus.out_valid && bus.sec_err, 1);
    cnt_clr = 1;
    @(posedge clk); #1 cnt_clr = 0;
    chk("clr_priority", sec_cnt, 0);

    // reset with both stages full
    bus.out_ready = 0;
    bus.data_in = 16'h0003;
    bus.chk_in = 6'h00;
    bus.in_valid = 1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 0;
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_in_ready", bus.in_ready, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_cnts", {sec_cnt, ded_cnt}, 0);
    bus.out_ready = 1;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!bus.in_valid || in_fire_s) begin
        rand_word(wd, wc);
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.data_in = wd;
        bus.chk_in = wc;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    cnt_clr = 0;
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
